// File: rtl/sp_pkg.sv
// Shared types and helpers for the series processor.
// State encoding, mode bit positions and Gray decode.
package sp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    GRAY,
    ACC,
    SORT,
    OUT
  } state_t;

  localparam int MODE_GRAY = 0;
  localparam int MODE_SUM  = 1;
  localparam int MODE_SORT = 2;

  localparam int GW = 32;

  // Suffix-XOR by doubling; zero upper bits make it width-agnostic.
  function automatic logic [GW-1:0] gray2bin(
    input logic [GW-1:0] g
  );
    logic [GW-1:0] b;
    b = g;
    for (int s = 1; s < GW; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/sp_clk_gate.sv
// Latch-based integrated clock gate.
// Enable is captured while clk is low to keep gclk glitch-free.
module sp_clk_gate (
  input  logic clk,
  input  logic en,
  output logic gclk
);

  logic en_l;

  always_latch begin
    if (!clk) en_l <= en;
  end

  assign gclk = clk & en_l;

endmodule

// File: rtl/sp_series_proc.sv
// Burst series processor: Gray decode, running sum, sort.
// Word buffer sits on a gated clock; control stays on clk.
module sp_series_proc
  import sp_pkg::*;
#(
  parameter int N_DATA = 6,
  parameter int DATA_W = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cg_en,
  input  logic              in_valid,
  input  logic [2:0]        in_mode,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  localparam int CNT_W = $clog2(N_DATA + 1);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(N_DATA - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        mode;
  logic [DATA_W-1:0] mem    [N_DATA];
  logic [DATA_W-1:0] gray_v [N_DATA];
  logic [DATA_W-1:0] sum_v  [N_DATA];
  logic [DATA_W-1:0] sort_v [N_DATA];
  logic [DATA_W-1:0] acc;
  logic              cg_on;
  logic              gclk;

  // The first word and reset land while IDLE, so both open the gate.
  assign cg_on = !cg_en || rst || in_valid
              || (state != IDLE);

  sp_clk_gate u_cg (
    .clk  (clk),
    .en   (cg_on),
    .gclk (gclk)
  );

  always_comb begin
    acc    = '0;
    sort_v = mem;
    for (int i = 0; i < N_DATA; i++) begin
      gray_v[i] = DATA_W'(gray2bin(GW'(mem[i])));
      acc       = acc + mem[i];
      sum_v[i]  = acc;
    end
    // Even passes pair (0,1),(2,3)..; odd passes (1,2),(3,4)..
    for (int i = 0; i < N_DATA - 1; i++) begin
      if ((i % 2) == int'(cnt[0])
          && mem[i] < mem[i+1]) begin
        sort_v[i]   = mem[i+1];
        sort_v[i+1] = mem[i];
      end
    end
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      mem <= '{default: '0};
    end else begin
      unique case (state)
        IDLE: if (in_valid) mem[0] <= in_data;
        LOAD: if (in_valid) mem[cnt] <= in_data;
        GRAY: if (mode[MODE_GRAY]) mem <= gray_v;
        ACC:  if (mode[MODE_SUM]) mem <= sum_v;
        SORT: if (mode[MODE_SORT]) mem <= sort_v;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mode      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= 1'b0;
      out_data  <= '0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            mode  <= in_mode;
            cnt   <= CNT_W'(1);
            state <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= GRAY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        GRAY: state <= ACC;
        ACC: begin
          cnt   <= '0;
          state <= SORT;
        end
        SORT: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= OUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUT: begin
          out_valid <= 1'b1;
          out_data  <= mem[cnt];
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
